// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the RV32M restoring divider.
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] DIV_F  = 2'b00;
  localparam logic [1:0] DIVU_F = 2'b01;
  localparam logic [1:0] REM_F  = 2'b10;
  localparam logic [1:0] REMU_F = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Magnitude of x; 0x80000000 maps to itself, which is exact when read unsigned.
  function automatic logic [DIV_XLEN-1:0] mag(input logic [DIV_XLEN-1:0] x,
                                              input logic               is_signed);
    return (is_signed && x[DIV_XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_restoring_if.sv
// Request/response bundle between EX and the divider.
interface div_restoring_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      fun_3;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] div_out;

  modport master (output start, fun_3, operand1, operand2, flush,
                  input  busy, done, div_out);
  modport slave  (input  start, fun_3, operand1, operand2, flush,
                  output busy, done, div_out);
endinterface

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial subtract, keep or restore.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    // A restored remainder is always below the divisor, so XLEN bits suffice.
    if (!trial[XLEN]) begin
      rem_out = trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_restoring.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring core on magnitudes plus sign fix-up.
module div_restoring
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  div_restoring_if.slave  bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_acc;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dsr_mag;
  logic            sel_rem;
  logic            quo_neg;
  logic            rem_neg;
  logic [XLEN-1:0] div_out_r;

  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic            req_signed;

  assign req_signed = (bus.fun_3 == DIV_F) || (bus.fun_3 == REM_F);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_acc),
    .quo_in  (quo),
    .divisor (dsr_mag),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_acc   <= '0;
      quo       <= '0;
      dsr_mag   <= '0;
      sel_rem   <= 1'b0;
      quo_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      div_out_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            sel_rem <= bus.fun_3[1];
            // Special cases resolve immediately and skip the iteration loop.
            if (bus.operand2 == '0) begin
              div_out_r <= bus.fun_3[1] ? bus.operand1 : '1;
              state     <= DONE;
            end else if (req_signed && bus.operand1 == MIN_NEG && bus.operand2 == '1) begin
              div_out_r <= bus.fun_3[1] ? '0 : MIN_NEG;
              state     <= DONE;
            end else begin
              rem_acc <= '0;
              quo     <= mag(bus.operand1, req_signed);
              dsr_mag <= mag(bus.operand2, req_signed);
              quo_neg <= req_signed && (bus.operand1[XLEN-1] ^ bus.operand2[XLEN-1]);
              rem_neg <= req_signed && bus.operand1[XLEN-1];
              cnt     <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            rem_acc <= rem_nxt;
            quo     <= quo_nxt;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DIV_ITERS - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            if (sel_rem) div_out_r <= rem_neg ? (~rem_acc + 1'b1) : rem_acc;
            else         div_out_r <= quo_neg ? (~quo + 1'b1) : quo;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == CALC) || (state == FIX);
  assign bus.done    = (state == DONE);
  assign bus.div_out = div_out_r;

endmodule

// File: tb/tb_div_restoring.sv
// Scoreboard bench for div_restoring: stimulus queues expected results, a monitor checks each done pulse.
module tb_div_restoring;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_restoring_if #(.XLEN(32)) bus();

  div_restoring #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] val;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_done: done at cycle %0d, want no done", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_val"}, bus.div_out, e.val);
        check({e.name, "_cycle"}, cyc, e.cyc);
        check({e.name, "_busy_in_done"}, {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic do_op(input string name, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input bit special,
                       input bit expect_done, output int unsigned t0);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.fun_3    = f;
    bus.operand1 = a;
    bus.operand2 = b;
    t0 = cyc;
    if (expect_done) begin
      e.name = name;
      e.val  = expv;
      e.cyc  = cyc + (special ? 1 : 34);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns in the done cycle so the next do_op lands on the following IDLE cycle.
  task automatic wait_done(input string name, input int unsigned exp_busy);
    int unsigned nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        if (bus.busy === 1'b1) nb++;
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 100 cycles, want done", name);
    end
    check({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic run_vec(input string name, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input bit special);
    int unsigned t0;
    do_op(name, f, a, b, expv, special, 1'b1, t0);
    wait_done(name, special ? 0 : 33);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    bus.start    = 1'b0;
    bus.fun_3    = 2'b00;
    bus.operand1 = '0;
    bus.operand2 = '0;
    bus.flush    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_div_out", bus.div_out, 32'd0);
    rst_n = 1'b1;

    run_vec("div_100_7",    DIV_F,  32'd100,      32'd7,        32'h0000000E, 1'b0);
    run_vec("rem_m7_2",     REM_F,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_vec("div_m7_2",     DIV_F,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_vec("remu_ffff_10", REMU_F, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 1'b0);
    run_vec("div_5_0",      DIV_F,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_vec("divu_5_0",     DIVU_F, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_vec("rem_5_0",      REM_F,  32'd5,        32'd0,        32'h00000005, 1'b1);
    run_vec("remu_min_0",   REMU_F, 32'h80000000, 32'd0,        32'h80000000, 1'b1);
    run_vec("div_ovf",      DIV_F,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_vec("rem_ovf",      REM_F,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    run_vec("divu_ovf",     DIVU_F, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_vec("b2b_divu",     DIVU_F, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0);
    run_vec("b2b_remu",     REMU_F, 32'hFFFFFFFF, 32'd3,        32'h00000000, 1'b0);
    run_vec("rem_m100_7",   REM_F,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0);
    run_vec("rem_100_m7",   REM_F,  32'd100,      32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_vec("div_100_m7",   DIV_F,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);

    // Flush during CALC at cycle 10: no done, busy drops, div_out keeps the last result.
    do_op("flush_calc", DIVU_F, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0, t0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_div_out", bus.div_out, 32'hFFFFFFF2);

    // Restart at cycle 12 of the flushed op (done at 46); a start during CALC is ignored.
    do_op("after_flush", DIVU_F, 32'd1000, 32'd7, 32'h0000008E, 1'b0, 1'b1, t0);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.operand1 = 32'd9;
    bus.operand2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("after_flush", 28);

    // Flush together with start in IDLE drops the request.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    bus.fun_3    = DIVU_F;
    bus.operand1 = 32'd50;
    bus.operand2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", {31'b0, bus.busy}, 32'd0);

    // Flush in DONE: done still pulses.
    do_op("flush_done", DIV_F, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1, t0);
    bus.flush = 1'b1;
    wait_done("flush_done", 0);
    @(negedge clk);
    bus.flush = 1'b0;

    // Reset at cycle 20 of an operation clears every output.
    do_op("reset_mid", DIVU_F, 32'hFFFFFFFF, 32'd7, 32'd0, 1'b0, 1'b0, t0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_mid_done", {31'b0, bus.done}, 32'd0);
    check("rst_mid_div_out", bus.div_out, 32'd0);
    rst_n = 1'b1;

    run_vec("post_reset", DIV_F, 32'd100, 32'd7, 32'h0000000E, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
